// File: rtl/bcd_counter_n.sv
// -----------------------------------------------------------------------------
// bcd_counter_n
//
// Purpose:
//   Multi-digit BCD up/down counter built from DIGITS cascaded decades.
//   Supports count enable, direction, synchronous parallel load with BCD
//   validation, wrap or saturate behaviour at the limit, and registered
//   one-cycle carry/borrow and load-error pulses.
//
// Parameters:
//   DIGITS    number of BCD decades (1..8); cnt is 4*DIGITS bits wide
//   WRAP      1: wrap 99..9 <-> 00..0 with a co pulse; 0: saturate at limit
//
// Ports:
//   clk       in   1          rising-edge clock
//   rst       in   1          asynchronous, active-low reset
//   en        in   1          count enable
//   up        in   1          direction: 1 = increment, 0 = decrement
//   load      in   1          synchronous parallel load request (wins over en)
//   load_val  in   4*DIGITS   BCD load value; digit i in bits [4i+3:4i]
//   cnt       out  4*DIGITS   registered BCD count; digit 0 least significant
//   co        out  1          registered one-cycle carry/borrow pulse on wrap
//   at_limit  out  1          combinational: all-9s when up=1, all-0s when up=0
//   err       out  1          registered one-cycle pulse on a rejected load
// -----------------------------------------------------------------------------
module bcd_counter_n #(
   parameter int DIGITS = 2,
   parameter int WRAP   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   cnt,
   output logic                  co,
   output logic                  at_limit,
   output logic                  err
);

   localparam int W = 4 * DIGITS;
   localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

   logic [W-1:0]      cnt_q;
   logic              co_q;
   logic              err_q;

   // Per-digit status of the current count and of the load value.
   logic [DIGITS-1:0] dig_is9;
   logic [DIGITS-1:0] dig_is0;
   logic [DIGITS-1:0] lv_ok;

   // Ripple enables: digit i moves only when every lower digit is at its
   // rollover value (9 going up, 0 going down). Digit 0 always moves.
   logic [DIGITS-1:0] low_all9;
   logic [DIGITS-1:0] low_all0;

   logic [W-1:0]      cnt_inc;
   logic [W-1:0]      cnt_dec;

   logic              all9;
   logic              all0;
   logic              load_ok;

   genvar i;
   generate
      for (i = 0; i < DIGITS; i++) begin : g_digit
         assign dig_is9[i] = (cnt_q[4*i +: 4] == 4'd9);
         assign dig_is0[i] = (cnt_q[4*i +: 4] == 4'd0);
         assign lv_ok[i]   = (load_val[4*i +: 4] <= 4'd9);

         if (i == 0) begin : g_first
            assign low_all9[i] = 1'b1;
            assign low_all0[i] = 1'b1;
         end else begin : g_rest
            assign low_all9[i] = low_all9[i-1] & dig_is9[i-1];
            assign low_all0[i] = low_all0[i-1] & dig_is0[i-1];
         end

         // Incremented and decremented digit; a digit only ever holds 0..9,
         // so the 9->0 and 0->9 cases are the only rollovers needed.
         always_comb begin
            cnt_inc[4*i +: 4] = cnt_q[4*i +: 4];
            if (low_all9[i]) begin
               if (dig_is9[i]) cnt_inc[4*i +: 4] = 4'd0;
               else            cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
            end
         end

         always_comb begin
            cnt_dec[4*i +: 4] = cnt_q[4*i +: 4];
            if (low_all0[i]) begin
               if (dig_is0[i]) cnt_dec[4*i +: 4] = 4'd9;
               else            cnt_dec[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
            end
         end
      end
   endgenerate

   assign all9     = &dig_is9;
   assign all0     = &dig_is0;
   assign load_ok  = &lv_ok;

   // Depends on the live direction input, not on en.
   assign at_limit = up ? all9 : all0;

   // co and err default to 0 on every edge so each is a single-cycle pulse.
   // A rejected load leaves the count untouched.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         co_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         co_q  <= 1'b0;
         err_q <= 1'b0;
         if (load) begin
            if (load_ok) cnt_q <= load_val;
            else         err_q <= 1'b1;
         end else if (en) begin
            if (at_limit) begin
               if (WRAP != 0) begin
                  cnt_q <= up ? '0 : ALL_NINES;
                  co_q  <= 1'b1;
               end
            end else begin
               cnt_q <= up ? cnt_inc : cnt_dec;
            end
         end
      end
   end

   assign cnt = cnt_q;
   assign co  = co_q;
   assign err = err_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// -----------------------------------------------------------------------------
// tb_bcd_counter_n
//
// Purpose:
//   Self-checking bench for bcd_counter_n. Two instances share one stimulus
//   stream: index 0 is DIGITS=2/WRAP=1, index 1 is DIGITS=2/WRAP=0. A
//   reference model keeps each count as a plain integer (0..99) and applies
//   the counting rules arithmetically; expected BCD is derived from it.
// -----------------------------------------------------------------------------
module tb_bcd_counter_n;

   localparam int DIGITS = 2;
   localparam int W      = 4 * DIGITS;
   localparam int MAXV   = 99;

   logic                 clk;
   logic                 rst;
   logic                 en;
   logic                 up;
   logic                 load;
   logic [W-1:0]         load_val;
   logic [1:0][W-1:0]    cnt_p;
   logic [1:0]           co_p;
   logic [1:0]           lim_p;
   logic [1:0]           err_p;

   int m_val [2];
   int m_co  [2];
   int m_err [2];

   int errors = 0;
   int checks = 0;

   bcd_counter_n #(.DIGITS(DIGITS), .WRAP(1)) u_wrap (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .cnt(cnt_p[0]), .co(co_p[0]), .at_limit(lim_p[0]), .err(err_p[0])
   );

   bcd_counter_n #(.DIGITS(DIGITS), .WRAP(0)) u_sat (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .cnt(cnt_p[1]), .co(co_p[1]), .at_limit(lim_p[1]), .err(err_p[1])
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model helpers ----------------
   function automatic logic [W-1:0] int2bcd(input int v);
      logic [W-1:0] r;
      int t;
      t = v;
      r = '0;
      for (int d = 0; d < DIGITS; d++) begin
         r[4*d +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic bit bcd_valid(input logic [W-1:0] b);
      for (int d = 0; d < DIGITS; d++)
         if (b[4*d +: 4] > 4'd9) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int bcd2int(input logic [W-1:0] b);
      int r;
      r = 0;
      for (int d = DIGITS - 1; d >= 0; d--) r = r * 10 + int'(b[4*d +: 4]);
      return r;
   endfunction

   function automatic bit exp_lim(input int k);
      return up ? (m_val[k] == MAXV) : (m_val[k] == 0);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_val[k] = 0; m_co[k] = 0; m_err[k] = 0;
      end
   endtask

   // Drives one request, advances one clock, updates the model, returns on
   // the following falling edge where outputs are stable.
   task automatic step(input logic e, input logic u, input logic l,
                       input logic [W-1:0] lv);
      en = e; up = u; load = l; load_val = lv;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         m_co[k]  = 0;
         m_err[k] = 0;
         if (l) begin
            if (bcd_valid(lv)) m_val[k] = bcd2int(lv);
            else               m_err[k] = 1;
         end else if (e) begin
            if (u) begin
               if (m_val[k] == MAXV) begin
                  if (k == 0) begin m_val[k] = 0; m_co[k] = 1; end
               end else m_val[k] = m_val[k] + 1;
            end else begin
               if (m_val[k] == 0) begin
                  if (k == 0) begin m_val[k] = MAXV; m_co[k] = 1; end
               end else m_val[k] = m_val[k] - 1;
            end
         end
      end
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
      #2 rst = 1'b0;
      model_reset();
      #6;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (cnt_p[k] !== 8'h00 || co_p[k] !== 1'b0 || err_p[k] !== 1'b0) begin
            errors++;
            $display("FAIL reset[%0d]: cnt=%h co=%b err=%b, want 00/0/0", k, cnt_p[k], co_p[k], err_p[k]);
         end
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_up_wrap();
      for (int n = 0; n < 100; n++) begin
         step(1'b1, 1'b1, 1'b0, '0);
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (cnt_p[k] !== int2bcd(m_val[k]) || co_p[k] !== 1'(m_co[k]) || lim_p[k] !== exp_lim(k)) begin
               errors++;
               $display("FAIL up_wrap[%0d] n=%0d: cnt=%h co=%b lim=%b, want %h/%0d/%b",
                        k, n, cnt_p[k], co_p[k], lim_p[k], int2bcd(m_val[k]), m_co[k], exp_lim(k));
            end
         end
      end
      checks++;
      if (cnt_p[0] !== 8'h00 || co_p[0] !== 1'b1) begin
         errors++;
         $display("FAIL up_wrap_end: cnt=%h co=%b, want 00/1", cnt_p[0], co_p[0]);
      end
   endtask

   task automatic test_down();
      step(1'b0, 1'b0, 1'b1, 8'h00);
      checks++;
      if (lim_p[0] !== 1'b1 || lim_p[1] !== 1'b1) begin
         errors++;
         $display("FAIL down_limit: at_limit=%b, want 11", lim_p);
      end
      step(1'b1, 1'b0, 1'b0, '0);
      checks++;
      if (cnt_p[0] !== 8'h99 || co_p[0] !== 1'b1) begin
         errors++;
         $display("FAIL down_wrap: cnt=%h co=%b, want 99/1", cnt_p[0], co_p[0]);
      end
      step(1'b1, 1'b0, 1'b0, '0);
      checks++;
      if (cnt_p[0] !== 8'h98 || co_p[0] !== 1'b0) begin
         errors++;
         $display("FAIL down_next: cnt=%h co=%b, want 98/0", cnt_p[0], co_p[0]);
      end
   endtask

   task automatic test_load();
      step(1'b0, 1'b1, 1'b1, 8'h57);
      for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 1'b0, '0);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (cnt_p[k] !== 8'h60 || cnt_p[k] !== int2bcd(m_val[k])) begin
            errors++;
            $display("FAIL load_carry[%0d]: cnt=%h, want 60", k, cnt_p[k]);
         end
      end
      step(1'b1, 1'b0, 1'b1, 8'h23);
      checks++;
      if (cnt_p[0] !== 8'h23 || cnt_p[1] !== 8'h23) begin
         errors++;
         $display("FAIL load_priority: cnt=%h/%h, want 23", cnt_p[0], cnt_p[1]);
      end
      step(1'b0, 1'b1, 1'b1, 8'h60);
   endtask

   task automatic test_bad_load();
      step(1'b1, 1'b1, 1'b1, 8'h5A);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (cnt_p[k] !== 8'h60 || err_p[k] !== 1'b1 || co_p[k] !== 1'b0) begin
            errors++;
            $display("FAIL bad_load[%0d]: cnt=%h err=%b co=%b, want 60/1/0", k, cnt_p[k], err_p[k], co_p[k]);
         end
      end
      step(1'b0, 1'b1, 1'b0, '0);
      checks++;
      if (err_p !== 2'b00 || cnt_p[0] !== 8'h60) begin
         errors++;
         $display("FAIL bad_load_clear: err=%b cnt=%h, want 00/60", err_p, cnt_p[0]);
      end
   endtask

   task automatic test_saturate();
      step(1'b0, 1'b1, 1'b1, 8'h98);
      for (int n = 0; n < 3; n++) begin
         step(1'b1, 1'b1, 1'b0, '0);
         checks++;
         if (cnt_p[1] !== 8'h99 || co_p[1] !== 1'b0 || cnt_p[1] !== int2bcd(m_val[1])) begin
            errors++;
            $display("FAIL sat_up n=%0d: cnt=%h co=%b, want 99/0", n, cnt_p[1], co_p[1]);
         end
      end
      step(1'b0, 1'b0, 1'b1, 8'h01);
      for (int n = 0; n < 3; n++) begin
         step(1'b1, 1'b0, 1'b0, '0);
         checks++;
         if (cnt_p[1] !== 8'h00 || co_p[1] !== 1'b0 || lim_p[1] !== 1'b1) begin
            errors++;
            $display("FAIL sat_down n=%0d: cnt=%h co=%b lim=%b, want 00/0/1", n, cnt_p[1], co_p[1], lim_p[1]);
         end
      end
   endtask

   task automatic test_async_reset_and_hold();
      step(1'b0, 1'b1, 1'b1, 8'h42);
      // Pending load plus mid-cycle reset: nothing may survive.
      en = 1'b1; load = 1'b1; load_val = 8'h33;
      #2 rst = 1'b0;
      model_reset();
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (cnt_p[k] !== 8'h00 || co_p[k] !== 1'b0 || err_p[k] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset[%0d]: cnt=%h co=%b err=%b, want 00/0/0", k, cnt_p[k], co_p[k], err_p[k]);
         end
      end
      en = 1'b0; load = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      step(1'b0, 1'b1, 1'b1, 8'h37);
      for (int n = 0; n < 5; n++) begin
         step(1'b0, n[0], 1'b0, 8'h11);
         checks++;
         if (cnt_p[0] !== 8'h37 || cnt_p[1] !== 8'h37 || co_p !== 2'b00) begin
            errors++;
            $display("FAIL hold n=%0d: cnt=%h/%h co=%b, want 37/0", n, cnt_p[0], cnt_p[1], co_p);
         end
      end
   endtask

   task automatic test_random();
      logic e, u, l;
      logic [W-1:0] lv;
      for (int n = 0; n < 400; n++) begin
         e  = ($urandom_range(0, 3) != 0);
         u  = 1'($urandom_range(0, 1));
         l  = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 1) == 1) lv = int2bcd($urandom_range(0, MAXV));
         else                           lv = W'($urandom_range(0, 255));
         step(e, u, l, lv);
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (cnt_p[k] !== int2bcd(m_val[k]) || co_p[k] !== 1'(m_co[k]) ||
                err_p[k] !== 1'(m_err[k]) || lim_p[k] !== exp_lim(k)) begin
               errors++;
               $display("FAIL random[%0d] n=%0d: cnt=%h co=%b err=%b lim=%b, want %h/%0d/%0d/%b",
                        k, n, cnt_p[k], co_p[k], err_p[k], lim_p[k],
                        int2bcd(m_val[k]), m_co[k], m_err[k], exp_lim(k));
            end
         end
      end
   endtask

   // ---------------- sequence ----------------
   initial begin
      test_reset();
      test_up_wrap();
      test_down();
      test_load();
      test_bad_load();
      test_saturate();
      test_async_reset_and_hold();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time bound so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end

endmodule
